// File: rtl/jcu_seq.sv
// Instruction sequencer: phase generator, step counter and run/pause/single/halt control,
// decoding the instruction register into phased set/enable strobes for the datapath.
module jcu_seq #(
    parameter int RBITS = 2,
    parameter int NSTEP = 6,
    parameter int IRW   = 4 + 2 * RBITS
) (
    input  logic                  CLK_clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  step_req,
    input  logic [IRW-1:0]        ir_bus,
    input  logic [3:0]            flags,
    output logic [NSTEP-1:0]      stp_bus,
    output logic                  clke,
    output logic                  clks,
    output logic [6:0]            sets,
    output logic [2:0]            enas,
    output logic [2**RBITS-1:0]   reg_s,
    output logic [2**RBITS-1:0]   reg_e,
    output logic                  bus1_bit1,
    output logic [2:0]            alu_op,
    output logic                  alu_ci,
    output logic                  halted
);

    localparam int NREG = 2 ** RBITS;
    localparam int SW   = $clog2(NSTEP);

    typedef enum logic [1:0] {
        S_PAUSED = 2'd0,
        S_RUN    = 2'd1,
        S_SINGLE = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    phase, phase_nxt;
    logic [SW-1:0] step, step_nxt;
    logic          halt_arm, halt_arm_nxt;

    logic active;
    logic boundary;
    logic halt_hit;

    // Instruction fields; the IR is numbered MSB-first, so ir[0] is ir_bus[IRW-1].
    logic              is_alu;
    logic [2:0]        op;
    logic [RBITS-1:0]  reg_a;
    logic [RBITS-1:0]  reg_b;
    logic [2*RBITS-1:0] operand;
    logic [3:0]        jmp_cond;
    logic              is_clf;
    logic              is_halt;
    logic              jump_ok;

    assign is_alu   = ir_bus[IRW-1];
    assign op       = ir_bus[IRW-2 -: 3];
    assign reg_a    = ir_bus[RBITS +: RBITS];
    assign reg_b    = ir_bus[0 +: RBITS];
    assign operand  = ir_bus[2*RBITS-1:0];
    assign jmp_cond = ir_bus[IRW-5 -: 4];
    assign is_clf   = !is_alu && (op == 3'b110) && (operand == '0);
    assign is_halt  = !is_alu && (op == 3'b110) && (operand == (2*RBITS)'(1));
    assign jump_ok  = |(flags & jmp_cond);

    // One-hot step, zero whenever the sequencer is not stepping.
    logic [NSTEP-1:0] st;

    assign active   = (state == S_RUN) || (state == S_SINGLE);
    assign boundary = active && (phase == 2'd3) && (step == SW'(NSTEP - 1));
    assign halt_hit = halt_arm || (st[5] && is_halt);

    always_ff @(posedge CLK_clk or posedge reset) begin
        if (reset) begin
            state    <= S_PAUSED;
            phase    <= 2'd0;
            step     <= '0;
            halt_arm <= 1'b0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            step     <= step_nxt;
            halt_arm <= halt_arm_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        phase_nxt    = 2'd0;
        step_nxt     = '0;
        halt_arm_nxt = 1'b0;
        if (active) begin
            phase_nxt = phase + 2'd1;
            step_nxt  = step;
            if (phase == 2'd3)
                step_nxt = (step == SW'(NSTEP - 1)) ? '0 : step + SW'(1);
            halt_arm_nxt = boundary ? 1'b0 : halt_hit;
        end
        unique case (state)
            S_PAUSED: begin
                if (run)
                    state_nxt = S_RUN;
                else if (step_req)
                    state_nxt = S_SINGLE;
            end
            S_RUN: begin
                if (boundary) begin
                    if (halt_hit)
                        state_nxt = S_HALTED;
                    else if (!run)
                        state_nxt = S_PAUSED;
                end
            end
            S_SINGLE: begin
                if (boundary)
                    state_nxt = halt_hit ? S_HALTED : S_PAUSED;
            end
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_PAUSED;
        endcase
    end

    always_comb begin
        st = '0;
        for (int i = 0; i < NSTEP; i++)
            st[i] = active && (step == SW'(i));
    end

    // Unphased per-step controls; the phasing below turns them into strobes.
    logic bus1, iar_e, ram_e, acc_e, rega_e, regb_e;
    logic ir_s, mar_s, iar_s, acc_s, ram_s, tmp_s, flags_s, regb_s;
    logic alu_step;

    always_comb begin
        bus1 = 1'b0; iar_e = 1'b0; ram_e = 1'b0; acc_e = 1'b0;
        rega_e = 1'b0; regb_e = 1'b0;
        ir_s = 1'b0; mar_s = 1'b0; iar_s = 1'b0; acc_s = 1'b0;
        ram_s = 1'b0; tmp_s = 1'b0; flags_s = 1'b0; regb_s = 1'b0;
        alu_step = 1'b0;

        if (st[0]) begin bus1 = 1'b1; iar_e = 1'b1; mar_s = 1'b1; acc_s = 1'b1; end
        if (st[1]) begin ram_e = 1'b1; ir_s = 1'b1; end
        if (st[2]) begin acc_e = 1'b1; iar_s = 1'b1; end

        if (is_alu) begin
            if (st[3]) begin regb_e = 1'b1; tmp_s = 1'b1; end
            if (st[4]) begin
                rega_e = 1'b1; alu_step = 1'b1; acc_s = 1'b1; flags_s = 1'b1;
            end
            // CMP only updates flags, so the write-back step stays quiet.
            if (st[5] && (op != 3'b111)) begin acc_e = 1'b1; regb_s = 1'b1; end
        end else begin
            unique case (op)
                3'b000: begin
                    if (st[3]) begin rega_e = 1'b1; mar_s = 1'b1; end
                    if (st[4]) begin ram_e = 1'b1; regb_s = 1'b1; end
                end
                3'b001: begin
                    if (st[3]) begin rega_e = 1'b1; mar_s = 1'b1; end
                    if (st[4]) begin regb_e = 1'b1; ram_s = 1'b1; end
                end
                3'b010: begin
                    if (st[3]) begin bus1 = 1'b1; iar_e = 1'b1; mar_s = 1'b1; acc_s = 1'b1; end
                    if (st[4]) begin ram_e = 1'b1; regb_s = 1'b1; end
                    if (st[5]) begin acc_e = 1'b1; iar_s = 1'b1; end
                end
                3'b011: begin
                    if (st[3]) begin regb_e = 1'b1; iar_s = 1'b1; end
                end
                3'b100: begin
                    if (st[3]) begin iar_e = 1'b1; mar_s = 1'b1; end
                    if (st[4]) begin ram_e = 1'b1; iar_s = 1'b1; end
                end
                3'b101: begin
                    if (st[3]) begin bus1 = 1'b1; iar_e = 1'b1; mar_s = 1'b1; acc_s = 1'b1; end
                    if (st[4]) begin acc_e = 1'b1; iar_s = 1'b1; end
                    if (st[5] && jump_ok) begin ram_e = 1'b1; iar_s = 1'b1; end
                end
                3'b110: begin
                    if (st[3] && is_clf) begin bus1 = 1'b1; flags_s = 1'b1; end
                end
                default: ;
            endcase
        end
    end

    logic ph_e, ph_s;

    assign ph_e = active && ((phase == 2'd1) || (phase == 2'd2));
    assign ph_s = active && (phase == 2'd2);

    always_comb begin
        stp_bus   = st;
        clke      = ph_e;
        clks      = ph_s;
        sets      = {ir_s, mar_s, iar_s, acc_s, ram_s, tmp_s, flags_s} & {7{ph_s}};
        enas      = {iar_e, ram_e, acc_e} & {3{ph_e}};
        bus1_bit1 = bus1;
        alu_op    = alu_step ? op : 3'b000;
        alu_ci    = alu_step;
        halted    = (state == S_HALTED);
        reg_s     = '0;
        reg_e     = '0;
        for (int i = 0; i < NREG; i++) begin
            reg_s[i] = ph_s && regb_s && (reg_b == RBITS'(i));
            reg_e[i] = ph_e && ((rega_e && (reg_a == RBITS'(i))) ||
                                (regb_e && (reg_b == RBITS'(i))));
        end
    end

endmodule

// File: tb/tb_jcu_seq.sv
// Directed bench for jcu_seq (RBITS=2, NSTEP=6): instruction-level strobe timing,
// pause/single-step, HALT and asynchronous reset.
module tb_jcu_seq;

    localparam int NC = 24;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       step_req;
    logic [7:0] ir_bus;
    logic [3:0] flags;
    logic [5:0] stp_bus;
    logic       clke, clks;
    logic [6:0] sets;
    logic [2:0] enas;
    logic [3:0] reg_s, reg_e;
    logic       bus1_bit1;
    logic [2:0] alu_op;
    logic       alu_ci;
    logic       halted;

    int checks = 0;
    int errors = 0;

    jcu_seq #(.RBITS(2), .NSTEP(6)) dut (
        .CLK_clk   (clk),
        .reset     (reset),
        .run       (run),
        .step_req  (step_req),
        .ir_bus    (ir_bus),
        .flags     (flags),
        .stp_bus   (stp_bus),
        .clke      (clke),
        .clks      (clks),
        .sets      (sets),
        .enas      (enas),
        .reg_s     (reg_s),
        .reg_e     (reg_e),
        .bus1_bit1 (bus1_bit1),
        .alu_op    (alu_op),
        .alu_ci    (alu_ci),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Per-cycle capture of one instruction, index = step*4 + phase.
    logic [5:0]  c_stp   [NC];
    logic [6:0]  c_sets  [NC];
    logic [2:0]  c_enas  [NC];
    logic [3:0]  c_reg_s [NC];
    logic [3:0]  c_reg_e [NC];
    logic [2:0]  c_alu_op[NC];
    logic        c_alu_ci[NC];
    logic        c_bus1  [NC];
    logic        c_halt  [NC];
    logic [23:0] c_clke_m, c_clks_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered one tick after the edge that starts step0/P0; leaves at the next boundary.
    task automatic run_instr(input logic [7:0] ir, input logic [3:0] fl, input int drop_at);
        ir_bus = ir;
        flags  = fl;
        for (int c = 0; c < NC; c++) begin
            #1;
            c_stp[c]    = stp_bus;
            c_sets[c]   = sets;
            c_enas[c]   = enas;
            c_reg_s[c]  = reg_s;
            c_reg_e[c]  = reg_e;
            c_alu_op[c] = alu_op;
            c_alu_ci[c] = alu_ci;
            c_bus1[c]   = bus1_bit1;
            c_halt[c]   = halted;
            c_clke_m[c] = clke;
            c_clks_m[c] = clks;
            if (c == drop_at) run = 1'b0;
            tick();
        end
    endtask

    initial begin
        int cnt;
        reset = 1'b1; run = 1'b0; step_req = 1'b0; ir_bus = 8'h00; flags = 4'h0;
        tick(); tick();
        check("reset_stp", 32'(stp_bus), 32'h0);
        check("reset_sets", 32'(sets), 32'h0);
        check("reset_clke", 32'(clke), 32'h0);
        check("reset_halted", 32'(halted), 32'h0);

        // LD R0,R0 in free-run
        reset = 1'b0;
        run   = 1'b1;
        tick();
        check("run_first_step", 32'(stp_bus), 32'h01);
        run_instr(8'h00, 4'h0, -1);
        check("ld_clks_pattern", 32'(c_clks_m), 32'h444444);
        check("ld_clke_pattern", 32'(c_clke_m), 32'h666666);
        check("ld_s5_onehot", 32'(c_stp[20]), 32'h20);
        check("ld_s0p0_sets", 32'(c_sets[0]), 32'h0);
        check("ld_s0_sets", 32'(c_sets[2]), 32'b0101000);
        check("ld_s0_enas", 32'(c_enas[2]), 32'b100);
        check("ld_s0_bus1", 32'(c_bus1[2]), 32'h1);
        check("ld_s1_sets", 32'(c_sets[6]), 32'b1000000);
        check("ld_s1_enas", 32'(c_enas[6]), 32'b010);
        check("ld_s2_sets", 32'(c_sets[10]), 32'b0010000);
        check("ld_s2_enas", 32'(c_enas[10]), 32'b001);
        check("ld_s3_reg_e", 32'(c_reg_e[13]), 32'b0001);
        check("ld_s3_sets", 32'(c_sets[14]), 32'b0100000);
        check("ld_s4_reg_s", 32'(c_reg_s[18]), 32'b0001);
        check("ld_s4_enas", 32'(c_enas[18]), 32'b010);
        check("ld_period", 32'(stp_bus), 32'h01);

        // ADD R1,R2
        run_instr(8'b1000_0110, 4'h0, -1);
        check("add_s3_reg_e", 32'(c_reg_e[14]), 32'b0100);
        check("add_s3_sets", 32'(c_sets[14]), 32'b0000010);
        check("add_s3_ci", 32'(c_alu_ci[14]), 32'h0);
        check("add_s4_reg_e", 32'(c_reg_e[18]), 32'b0010);
        check("add_s4_sets", 32'(c_sets[18]), 32'b0001001);
        check("add_s4_op", 32'(c_alu_op[18]), 32'b000);
        check("add_s4_ci", 32'(c_alu_ci[18]), 32'h1);
        check("add_s5_reg_s", 32'(c_reg_s[22]), 32'b0100);
        check("add_s5_enas", 32'(c_enas[22]), 32'b001);

        // ALU op 011, regA=R3, regB=R0
        run_instr(8'b1011_1100, 4'h0, -1);
        check("alu3_s4_op", 32'(c_alu_op[18]), 32'b011);
        check("alu3_s3_op", 32'(c_alu_op[14]), 32'b000);
        check("alu3_s4_reg_e", 32'(c_reg_e[18]), 32'b1000);
        check("alu3_s5_reg_s", 32'(c_reg_s[22]), 32'b0001);

        // CMP R0,R1
        run_instr(8'b1111_0001, 4'h0, -1);
        check("cmp_s3_reg_e", 32'(c_reg_e[14]), 32'b0010);
        check("cmp_s3_sets", 32'(c_sets[14]), 32'b0000010);
        check("cmp_s4_reg_e", 32'(c_reg_e[18]), 32'b0001);
        check("cmp_s4_op", 32'(c_alu_op[18]), 32'b111);
        check("cmp_s5_reg_s", 32'(c_reg_s[22]), 32'b0000);
        check("cmp_s5_enas", 32'(c_enas[22]), 32'b000);

        // JMPIF taken / not taken
        run_instr(8'b0101_0010, 4'b0010, -1);
        check("jif_s3_sets", 32'(c_sets[14]), 32'b0101000);
        check("jif_s3_enas", 32'(c_enas[14]), 32'b100);
        check("jif_s4_enas", 32'(c_enas[18]), 32'b001);
        check("jif_s4_sets", 32'(c_sets[18]), 32'b0010000);
        check("jif_s5_enas", 32'(c_enas[22]), 32'b010);
        check("jif_s5_sets", 32'(c_sets[22]), 32'b0010000);
        run_instr(8'b0101_0010, 4'b0001, -1);
        check("jifn_s5_enas", 32'(c_enas[22]), 32'b000);
        check("jifn_s5_sets", 32'(c_sets[22]), 32'b0000000);

        // Drop run at step 3: instruction completes, then paused
        run_instr(8'h00, 4'h0, 12);
        check("pause_s5_active", 32'(c_stp[20]), 32'h20);
        check("pause_s5_clks", 32'(c_clks_m[22]), 32'h1);
        check("pause_stp", 32'(stp_bus), 32'h0);
        tick(); tick();
        check("pause_hold", 32'(stp_bus), 32'h0);

        // Single step
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (stp_bus != 6'h0) cnt++;
            tick();
        end
        check("single_cycles", 32'(cnt), 32'd24);
        check("single_paused", 32'(stp_bus), 32'h0);

        // CLF in free-run
        run = 1'b1;
        tick();
        run_instr(8'b0110_0000, 4'h0, -1);
        check("clf_s3_sets", 32'(c_sets[14]), 32'b0000001);
        check("clf_s3_bus1", 32'(c_bus1[12]), 32'h1);

        // Reset asserted mid-instruction
        ir_bus = 8'h00;
        repeat (10) tick();
        check("midrst_pre_clks", 32'(clks), 32'h1);
        reset = 1'b1;
        run   = 1'b0;
        #1;
        check("midrst_stp", 32'(stp_bus), 32'h0);
        check("midrst_clks", 32'(clks), 32'h0);
        check("midrst_sets", 32'(sets), 32'h0);
        check("midrst_enas", 32'(enas), 32'h0);
        #2;
        reset = 1'b0;
        tick();
        check("midrst_after", 32'(stp_bus), 32'h0);

        // HALT
        run = 1'b1;
        tick();
        run_instr(8'b0110_0001, 4'h0, -1);
        check("halt_s3_sets", 32'(c_sets[14]), 32'h0);
        check("halt_s5_sets", 32'(c_sets[22]), 32'h0);
        check("halt_s5_enas", 32'(c_enas[22]), 32'h0);
        check("halt_pre_boundary", 32'(c_halt[23]), 32'h0);
        check("halt_set", 32'(halted), 32'h1);
        check("halt_stp", 32'(stp_bus), 32'h0);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        repeat (5) tick();
        check("halt_sticky", 32'(halted), 32'h1);
        check("halt_stp_idle", 32'(stp_bus), 32'h0);
        reset = 1'b1;
        #1;
        check("halt_reset", 32'(halted), 32'h0);
        reset = 1'b0;
        run   = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
